pio_irq: RTL
============

Name: pio_irq

Overview:
- Second-generation parallel I/O block. Adds the following over the first-generation PIO:
  - per-bit output set/clear aliases
  - byte-strobe-aware writes
  - multi-stage input synchroniser
  - per-bit maskable, level- or rising-edge-triggered interrupts with write-1-to-clear pending bits
  - SLVERR on unmapped offsets
- Sits on one AXI4-Lite control target and drives SoC pads.

Parameters:
- addrWidth, 32, AXI address width
- dataWidth, 32, AXI data width
- pioWidth, 16, number of I/O bits; 1..dataWidth
- writeStrobeWidth, 4, dataWidth/8
- syncStages, 2, input synchroniser flops; >= 1

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- t_ctrl_awvalid/awready  in/out  1  AW handshake
- t_ctrl_awaddr  in  addrWidth  write address; only bits [4:2] decoded
- t_ctrl_awprot  in  3  ignored
- t_ctrl_wvalid/wready  in/out  1  W handshake
- t_ctrl_wdata  in  dataWidth  write data
- t_ctrl_wstrb  in  writeStrobeWidth  byte enables
- t_ctrl_bvalid/bready  out/in  1  B handshake
- t_ctrl_bresp  out  2  OKAY(00) or SLVERR(10)
- t_ctrl_arvalid/arready  in/out  1  AR handshake
- t_ctrl_araddr  in  addrWidth  read address; bits [4:2] decoded
- t_ctrl_arprot  in  3  ignored
- t_ctrl_rvalid/rready  out/in  1  R handshake
- t_ctrl_rdata  out  dataWidth  read data; bits above pioWidth are 0
- t_ctrl_rresp  out  2  OKAY/SLVERR
- irq  out  1  |(ipend & ien)
- odata  out  pioWidth  pad output values
- oenable  out  pioWidth  pad output enables
- idata  in  pioWidth  asynchronous pad inputs

Behaviour:
- Reset (synchronous, active-high):
  - Registers and outputs go to 0: odata, oenable, ien, imode, ipend, the synchroniser chain and the edge-history register.
  - Both FSMs return to idle. No bvalid/rvalid pulse is issued for any transaction in flight.
- Register map (byte offset; the register index is addr[4:2]):
  - 0x00 ODATA  RW
  - 0x04 OENABLE  RW
  - 0x08 IDATA  RO, synchronised value
  - 0x0C IEN  RW
  - 0x10 IMODE  RW; per bit, 0 = level-high, 1 = rising edge
  - 0x14 IPEND  RW1C
  - 0x18 OSET  WO, write 1 sets the ODATA bit; reads 0
  - 0x1C OCLR  WO, write 1 clears the ODATA bit; reads 0
  - Offsets are modulo 32. addr[1:0] is ignored.
- Unmapped accesses: writes to IDATA return SLVERR and have no effect. Reads of OSET/OCLR return 0 with OKAY.
- Write strobes: byte k of a register is updated only if wstrb[k]=1. For OSET, OCLR and IPEND, a bit is acted on only if its byte is strobed.
- Write FSM states: W_I, W_A (address held), W_W (data held), W_B (response).
  - W_I: awready = wready = 1.
    - AW and W together -> commit the write, go to W_B.
    - AW only -> latch the address, go to W_A.
    - W only -> latch data and strobe, go to W_W.
  - W_A: wready=1, awready=0. W handshake -> commit, go to W_B.
  - W_W: awready=1, wready=0. AW handshake -> commit, go to W_B.
  - W_B: bvalid=1, bresp registered at commit. Handshake -> W_I.
  - Register updates are visible on the cycle after commit. Minimum latency is 1 cycle from handshake to bvalid.
- Read FSM states: R_I, R_D.
  - R_I: arready=1. Handshake -> R_D.
  - R_D: rvalid=1. rdata and rresp are captured at the AR handshake and held stable until rready. Then -> R_I.
  - Read and write channels operate concurrently and independently. Reading a register in the cycle it is written returns the old value.
- Input path: idata passes through syncStages flops to give isync; iprev is isync delayed by 1.
  - Condition per bit i: imode[i] ? (isync[i] & ~iprev[i]) : isync[i].
  - The condition sets ipend[i] every cycle it holds.
  - W1C clears ipend[i]. If set and W1C occur in the same cycle, set wins.
  - Level-mode bits cannot be cleared while the input stays high.
- irq is combinational from registered ipend & ien, with no extra latency.
- Latency from an idata edge to irq: syncStages+1 cycles.
- ODATA write, OSET and OCLR are mutually exclusive per transaction, so no priority between them is needed.

Decomposition:
- Package pio_irq_pkg holds:
  - register offset localparams (REG_ODATA ... REG_OCLR)
  - write-FSM and read-FSM state encodings (one-hot)
  - RESP_OKAY and RESP_SLVERR
- One sub-module, pio_irq_sync: a parametrised syncStages-deep, pioWidth-wide synchroniser with an edge-history output.
- Strobe masking uses an inline function in the package.

Test Plan:
All scenarios use pioWidth=16 and syncStages=2.
1. Reset, then read all 8 offsets -> all return 0 with OKAY. irq=0, odata=0, oenable=0.
2. AW 0x00 + W 0x0000A5C3 with wstrb=4'b0001 -> odata=0x00C3. Then OSET 0x0100 -> odata=0x01C3. Then OCLR 0x0003 -> odata=0x01C0. bresp=OKAY each time.
3. W presented 3 cycles before AW (W_W path), then AW 0x04 with W 0xFFFF -> oenable=0xFFFF the cycle after AW. bvalid is held across 5 cycles of bready=0.
4. Write IEN=0x0001 and IMODE=0x0001, drive idata[0] 0->1 -> irq rises 3 cycles later. Hold idata high and W1C IPEND=0x0001 -> irq falls and stays 0.
5. IMODE=0 with IEN=0x0002, hold idata[1]=1, W1C IPEND -> ipend[1] stays 1 and irq stays 1. Drop idata[1], then W1C -> irq=0.
6. Write 0x08 -> SLVERR and IDATA unchanged. Assert reset during W_A -> the next AW+W completes normally with no stale bvalid.

Source files
------------

// File: rtl/pio_irq_pkg.sv
// Shared definitions for the interrupt-capable parallel I/O block:
// register map, response codes, FSM encodings and byte-strobe expansion.
package pio_irq_pkg;

  localparam logic [2:0] REG_ODATA   = 3'd0;
  localparam logic [2:0] REG_OENABLE = 3'd1;
  localparam logic [2:0] REG_IDATA   = 3'd2;
  localparam logic [2:0] REG_IEN     = 3'd3;
  localparam logic [2:0] REG_IMODE   = 3'd4;
  localparam logic [2:0] REG_IPEND   = 3'd5;
  localparam logic [2:0] REG_OSET    = 3'd6;
  localparam logic [2:0] REG_OCLR    = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    W_I = 4'b0001,
    W_A = 4'b0010,
    W_W = 4'b0100,
    W_B = 4'b1000
  } wr_state_e;

  typedef enum logic [1:0] {
    R_I = 2'b01,
    R_D = 2'b10
  } rd_state_e;

  // Expands up to eight byte enables into a 64-bit bit mask; callers slice what they need.
  function automatic logic [63:0] strobe_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      m[k*8 +: 8] = {8{strb[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pio_irq_if.sv
// AXI4-Lite control channel bundle for pio_irq; the master side drives requests,
// the slave side is the register block.
interface pio_irq_if #(
  parameter int addrWidth        = 32,
  parameter int dataWidth        = 32,
  parameter int writeStrobeWidth = 4
);
  logic                        awvalid;
  logic                        awready;
  logic [addrWidth-1:0]        awaddr;
  logic [2:0]                  awprot;
  logic                        wvalid;
  logic                        wready;
  logic [dataWidth-1:0]        wdata;
  logic [writeStrobeWidth-1:0] wstrb;
  logic                        bvalid;
  logic                        bready;
  logic [1:0]                  bresp;
  logic                        arvalid;
  logic                        arready;
  logic [addrWidth-1:0]        araddr;
  logic [2:0]                  arprot;
  logic                        rvalid;
  logic                        rready;
  logic [dataWidth-1:0]        rdata;
  logic [1:0]                  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/pio_irq_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs, plus a one-cycle
// history of the synchronised value used for rising-edge detection.
module pio_irq_sync #(
  parameter int pioWidth   = 16,
  parameter int syncStages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [pioWidth-1:0] idata,
  output logic [pioWidth-1:0] isync,
  output logic [pioWidth-1:0] iprev
);

  logic [pioWidth-1:0] chain_q [syncStages];
  logic [pioWidth-1:0] chain_d [syncStages];
  logic [pioWidth-1:0] iprev_q;
  logic [pioWidth-1:0] iprev_d;

  always_comb begin
    chain_d[0] = idata;
    for (int s = 1; s < syncStages; s++) begin
      chain_d[s] = chain_q[s-1];
    end
    iprev_d = chain_q[syncStages-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < syncStages; s++) begin
        chain_q[s] <= '0;
      end
      iprev_q <= '0;
    end else begin
      for (int s = 0; s < syncStages; s++) begin
        chain_q[s] <= chain_d[s];
      end
      iprev_q <= iprev_d;
    end
  end

  assign isync = chain_q[syncStages-1];
  assign iprev = iprev_q;

endmodule

// File: rtl/pio_irq.sv
// Parallel I/O register block with set/clear aliases, synchronised inputs and
// per-bit maskable level/rising-edge interrupts, behind an AXI4-Lite target.
module pio_irq
  import pio_irq_pkg::*;
#(
  parameter int addrWidth        = 32,
  parameter int dataWidth        = 32,
  parameter int pioWidth         = 16,
  parameter int writeStrobeWidth = 4,
  parameter int syncStages       = 2
) (
  input  logic                clk,
  input  logic                reset,
  pio_irq_if.slave            t_ctrl,
  output logic                irq,
  output logic [pioWidth-1:0] odata,
  output logic [pioWidth-1:0] oenable,
  input  logic [pioWidth-1:0] idata
);

  wr_state_e                   wr_state_q, wr_state_d;
  rd_state_e                   rd_state_q, rd_state_d;
  logic [2:0]                  awidx_q, awidx_d;
  logic [dataWidth-1:0]        wdata_q, wdata_d;
  logic [writeStrobeWidth-1:0] wstrb_q, wstrb_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [dataWidth-1:0]        rdata_q, rdata_d;

  logic [pioWidth-1:0] odata_q, odata_d;
  logic [pioWidth-1:0] oen_q, oen_d;
  logic [pioWidth-1:0] ien_q, ien_d;
  logic [pioWidth-1:0] imode_q, imode_d;
  logic [pioWidth-1:0] ipend_q, ipend_d;

  logic                        commit;
  logic [2:0]                  c_idx;
  logic [dataWidth-1:0]        c_data;
  logic [writeStrobeWidth-1:0] c_strb;
  logic                        awready, wready, bvalid, arready, rvalid;

  logic [7:0]          strb_ext;
  logic [63:0]         byte_mask;
  logic [pioWidth-1:0] bit_mask, wbits, w1c, irq_cond, rd_val;
  logic [pioWidth-1:0] isync, iprev;

  logic [addrWidth-1:0] unused_awaddr, unused_araddr;
  logic                 unused_bits;

  pio_irq_sync #(
    .pioWidth  (pioWidth),
    .syncStages(syncStages)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .idata(idata),
    .isync(isync),
    .iprev(iprev)
  );

  // The commit source mixes latched and live channel values depending on which half arrived first.
  always_comb begin
    wr_state_d = wr_state_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    c_idx      = awidx_q;
    c_data     = wdata_q;
    c_strb     = wstrb_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state_q)
      W_I: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (t_ctrl.awvalid && t_ctrl.wvalid) begin
          commit     = 1'b1;
          c_idx      = t_ctrl.awaddr[4:2];
          c_data     = t_ctrl.wdata;
          c_strb     = t_ctrl.wstrb;
          wr_state_d = W_B;
        end else if (t_ctrl.awvalid) begin
          awidx_d    = t_ctrl.awaddr[4:2];
          wr_state_d = W_A;
        end else if (t_ctrl.wvalid) begin
          wdata_d    = t_ctrl.wdata;
          wstrb_d    = t_ctrl.wstrb;
          wr_state_d = W_W;
        end
      end
      W_A: begin
        wready = 1'b1;
        if (t_ctrl.wvalid) begin
          commit     = 1'b1;
          c_data     = t_ctrl.wdata;
          c_strb     = t_ctrl.wstrb;
          wr_state_d = W_B;
        end
      end
      W_W: begin
        awready = 1'b1;
        if (t_ctrl.awvalid) begin
          commit     = 1'b1;
          c_idx      = t_ctrl.awaddr[4:2];
          wr_state_d = W_B;
        end
      end
      W_B: begin
        bvalid = 1'b1;
        if (t_ctrl.bready) begin
          wr_state_d = W_I;
        end
      end
      default: wr_state_d = W_I;
    endcase
    if (commit) begin
      bresp_d = (c_idx == REG_IDATA) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_comb begin
    strb_ext = '0;
    strb_ext[writeStrobeWidth-1:0] = c_strb;
  end

  assign byte_mask = strobe_mask(strb_ext);
  assign bit_mask  = byte_mask[pioWidth-1:0];
  assign wbits     = c_data[pioWidth-1:0] & bit_mask;

  // A pending bit set by its condition this cycle survives a simultaneous W1C.
  always_comb begin
    odata_d = odata_q;
    oen_d   = oen_q;
    ien_d   = ien_q;
    imode_d = imode_q;
    w1c     = '0;
    if (commit) begin
      case (c_idx)
        REG_ODATA:   odata_d = (odata_q & ~bit_mask) | wbits;
        REG_OENABLE: oen_d   = (oen_q   & ~bit_mask) | wbits;
        REG_IEN:     ien_d   = (ien_q   & ~bit_mask) | wbits;
        REG_IMODE:   imode_d = (imode_q & ~bit_mask) | wbits;
        REG_IPEND:   w1c     = wbits;
        REG_OSET:    odata_d = odata_q | wbits;
        REG_OCLR:    odata_d = odata_q & ~wbits;
        default:     ;
      endcase
    end
    irq_cond = (imode_q & isync & ~iprev) | (~imode_q & isync);
    ipend_d  = (ipend_q & ~w1c) | irq_cond;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (t_ctrl.araddr[4:2])
      REG_ODATA:   rd_val = odata_q;
      REG_OENABLE: rd_val = oen_q;
      REG_IDATA:   rd_val = isync;
      REG_IEN:     rd_val = ien_q;
      REG_IMODE:   rd_val = imode_q;
      REG_IPEND:   rd_val = ipend_q;
      default:     rd_val = '0;
    endcase
    case (rd_state_q)
      R_I: begin
        arready = 1'b1;
        if (t_ctrl.arvalid) begin
          rdata_d = '0;
          rdata_d[pioWidth-1:0] = rd_val;
          rd_state_d = R_D;
        end
      end
      R_D: begin
        rvalid = 1'b1;
        if (t_ctrl.rready) begin
          rd_state_d = R_I;
        end
      end
      default: rd_state_d = R_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= W_I;
      rd_state_q <= R_I;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      odata_q    <= '0;
      oen_q      <= '0;
      ien_q      <= '0;
      imode_q    <= '0;
      ipend_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      odata_q    <= odata_d;
      oen_q      <= oen_d;
      ien_q      <= ien_d;
      imode_q    <= imode_d;
      ipend_q    <= ipend_d;
    end
  end

  assign t_ctrl.awready = awready;
  assign t_ctrl.wready  = wready;
  assign t_ctrl.bvalid  = bvalid;
  assign t_ctrl.bresp   = bresp_q;
  assign t_ctrl.arready = arready;
  assign t_ctrl.rvalid  = rvalid;
  assign t_ctrl.rdata   = rdata_q;
  assign t_ctrl.rresp   = RESP_OKAY;

  assign irq     = |(ipend_q & ien_q);
  assign odata   = odata_q;
  assign oenable = oen_q;

  assign unused_awaddr = t_ctrl.awaddr;
  assign unused_araddr = t_ctrl.araddr;
  assign unused_bits   = ^{t_ctrl.awprot, t_ctrl.arprot, unused_awaddr, unused_araddr,
                           c_data, byte_mask};

endmodule
